alu_cmd_sequencer: RTL and testbench

Front-end stage sitting directly upstream of the 4-bit ALU chip. It captures operand/opcode commands from the input switches on a debounced-by-synchronizer pushbutton edge, buffers them in a small FIFO, and issues them one at a time to the combinational ALU. It registers each ALU result back with a valid pulse. The ALU's operand and op inputs are thereby driven from stable registers instead of raw switches.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_cmd_fifo.sv | 81 ++++++++
 rtl/alu_cmd_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Types and constants shared by the 4-bit ALU chip and its command sequencer.
//   ALU_DATA_W  : default operand/result width of the ALU datapath
//   alu_op_t    : ALU opcode encoding (ADD=0 .. LT=7)
//   alu_cmd_t   : one queued command {a, b, op}
//   seq_state_t : sequencer FSM states
// Helpers:
//   is_chain_op : opcode has bit 3 set (the accumulate-chain range 8..15)
//   base_op     : opcode with bit 3 cleared (the ALU operation a chain op runs)
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DATA_W = 4;

    typedef enum logic [3:0] {
        ADD      = 4'd0,
        SUBTRACT = 4'd1,
        AND      = 4'd2,
        OR       = 4'd3,
        EQUALS   = 4'd4,
        NOT      = 4'd5,
        GT       = 4'd6,
        LT       = 4'd7
    } alu_op_t;

    // op is kept as a raw 4-bit field rather than alu_op_t because codes
    // 8..15 are legal in the queue and must travel through unchanged.
    typedef struct packed {
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
        logic [3:0]            op;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_CAPTURE = 2'd2
    } seq_state_t;

    function automatic logic is_chain_op(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic [3:0] base_op(input logic [3:0] op);
        return {1'b0, op[2:0]};
    endfunction

endpackage : alu_pkg

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous FIFO of alu_cmd_t entries. The caller owns the accept policy:
// push is only asserted for a command that is to be stored, and pop only
// while the FIFO is non-empty. Status flags are registered.
// Parameters:
//   DEPTH : number of entries, power of two, >= 2
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : store wdata this cycle
//   pop        : advance the read pointer this cycle
//   wdata      : command to store
//   rdata      : command at the head (valid while empty=0)
//   full       : registered, count == DEPTH
//   empty      : registered, count == 0
//   count      : number of stored entries (one bit wider than the pointers)
// -----------------------------------------------------------------------------
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  alu_cmd_t                 wdata,
    output alu_cmd_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    alu_cmd_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_next;

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            // Power-of-two depth: pointers wrap naturally at their width.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // NOTE: the storage array has no reset; stale entries are never read
    // because the pointers and count are reset, and an unreset array maps
    // onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule : alu_cmd_fifo

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Front end for the combinational 4-bit ALU. A pushbutton strobe (2-flop
// synchronizer + edge flop) captures {cmd_a, cmd_b, cmd_op} from the switches
// into a command FIFO. While run is high the FSM issues queued commands one
// at a time to registered ALU inputs, waits one settle cycle, then captures
// the ALU output into result with a one-cycle result_valid pulse.
// Optional build macro:
//   ACC_CHAIN_EN : opcodes 8..15 become chain ops; alu_a is taken from the
//                  current result register and alu_op = {1'b0, op[2:0]}.
//                  Undefined: opcodes are forwarded verbatim.
// Parameters:
//   FIFO_DEPTH : command FIFO entries (power of two, >= 2)
//   DATA_W     : operand/result width, must equal alu_pkg::ALU_DATA_W
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   ena                 : low freezes everything except the synchronizer
//   cmd_btn             : raw asynchronous push strobe
//   cmd_a, cmd_b, cmd_op: command fields from the switches
//   run                 : level, permits draining the FIFO into the ALU
//   alu_a, alu_b, alu_op: registered ALU inputs
//   alu_result          : combinational ALU output
//   result              : last captured ALU result
//   result_valid        : one-cycle pulse per captured result
//   fifo_empty/full     : registered FIFO status
//   overflow            : sticky, push attempted while full
//   busy                : FSM not in IDLE
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              cmd_btn,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [3:0]        cmd_op,
    input  logic              run,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              overflow,
    output logic              busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]        btn_sync;
    logic              btn_rise;
    logic              push_req;
    logic              push_ok;
    logic              push_drop;
    logic              pop;
    logic              capture;
    seq_state_t        state;
    seq_state_t        state_next;
    alu_cmd_t          push_cmd;
    alu_cmd_t          head_cmd;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] issue_a;
    logic [3:0]        issue_op;

    // Synchronizer stages [1:0], edge-detect history in [2]. Runs even with
    // ena low, so an edge seen while disabled is consumed rather than held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= '0;
        end else begin
            btn_sync <= {btn_sync[1:0], cmd_btn};
        end
    end

    assign btn_rise = btn_sync[1] & ~btn_sync[2];
    assign push_req = btn_rise & ena;

    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign push_ok   = push_req && ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop);
    assign push_drop = push_req && !push_ok;

    assign push_cmd = '{a: ALU_DATA_W'(cmd_a), b: ALU_DATA_W'(cmd_b), op: cmd_op};

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop),
        .wdata (push_cmd),
        .rdata (head_cmd),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // FSM next state. With ena low every branch holds, so the FSM freezes.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ena && run && !fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Operands have been stable on the ALU for a full cycle;
                // its output is sampled on the way into CAPTURE.
                if (ena) begin
                    capture    = 1'b1;
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (ena) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operands presented to the ALU for the command at the FIFO head.
    always_comb begin
        issue_a  = DATA_W'(head_cmd.a);
        issue_op = head_cmd.op;
`ifdef ACC_CHAIN_EN
        if (is_chain_op(head_cmd.op)) begin
            issue_a  = result;
            issue_op = base_op(head_cmd.op);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= 4'(ADD);
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                alu_a  <= issue_a;
                alu_b  <= DATA_W'(head_cmd.b);
                alu_op <= issue_op;
            end
            if (capture)   result   <= alu_result;
            if (push_drop) overflow <= 1'b1;
        end
    end

    // result holds the captured value for the whole CAPTURE cycle; ena low
    // masks the pulse while the FSM is frozen there.
    assign result_valid = ena && (state == ST_CAPTURE);
    assign busy         = (state != ST_IDLE);

endmodule : alu_cmd_sequencer

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Scoreboard bench for alu_cmd_sequencer. A behavioural ALU drives alu_result.
// Every accepted push enqueues the expected {alu_a, alu_b, alu_op, result};
// a monitor pops and compares whenever result_valid is seen.
// Honours ACC_CHAIN_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int W     = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic         cmd_btn = 1'b0;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic [3:0]   cmd_op = '0;
    logic         run = 1'b0;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_result;
    logic [W-1:0] result;
    logic         result_valid;
    logic         fifo_empty;
    logic         fifo_full;
    logic         overflow;
    logic         busy;

    alu_cmd_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .DATA_W     (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .cmd_btn      (cmd_btn),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .run          (run),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .result       (result),
        .result_valid (result_valid),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit ALU.
    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return (a == b) ? 4'd1 : 4'd0;
            4'd5:    return ~a;
            4'd6:    return (a > b) ? 4'd1 : 4'd0;
            4'd7:    return (a < b) ? 4'd1 : 4'd0;
            default: return 4'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [3:0] res;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_results = 0;
    logic [3:0] model_acc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected outcome of one accepted command, in push order.
    task automatic model_push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.op = op;
`ifdef ACC_CHAIN_EN
        if (op >= 4'd8) begin
            e.a  = model_acc;
            e.op = op - 4'd8;
        end
`endif
        e.res     = alu_f(e.a, e.b, e.op);
        model_acc = e.res;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One button press: fields stay stable until well past the edge-detect cycle.
    task automatic press(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                         input int hold, input int gap, input bit accepted);
        cmd_a   = a;
        cmd_b   = b;
        cmd_op  = op;
        cmd_btn = 1'b1;
        if (accepted) model_push(a, b, op);
        repeat (hold) step();
        cmd_btn = 1'b0;
        repeat (3 + gap) step();
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            step();
            t++;
        end
        repeat (3) step();
        check({"drain_", tag}, sb.size(), 0);
    endtask

    task automatic reset_dut();
        cmd_btn = 1'b0;
        rst_n   = 1'b0;
        sb.delete();
        model_acc = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_a"},        alu_a, 0);
        check({tag, "_alu_b"},        alu_b, 0);
        check({tag, "_alu_op"},       alu_op, 0);
        check({tag, "_result"},       result, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_fifo_empty"},   fifo_empty, 1);
        check({tag, "_fifo_full"},    fifo_full, 0);
        check({tag, "_overflow"},     overflow, 0);
        check({tag, "_busy"},         busy, 0);
    endtask

    // Monitor: every result_valid pulse must match the oldest pending command.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && result_valid) begin
                if (sb.size() == 0) begin
                    check("result_valid_without_pending", result_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("res%0d_alu_a", n_results),  alu_a,  e.a);
                    check($sformatf("res%0d_alu_b", n_results),  alu_b,  e.b);
                    check($sformatf("res%0d_alu_op", n_results), alu_op, e.op);
                    check($sformatf("res%0d_result", n_results), result, e.res);
                    n_results++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;

        // Reset values while rst_n is held low.
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        rst_n = 1'b1;
        step();

        // Single command 3+4.
        run = 1'b1;
        press(4'd3, 4'd4, 4'(ADD), 1, 4, 1'b1);
        drain("single");
        @(negedge clk);
        check("single_result_7", result, 7);
        check("single_fifo_empty", fifo_empty, 1);

        // Five pushes with run low: fill, then overflow.
        reset_dut();
        run = 1'b0;
        for (int i = 0; i < 4; i++) press(4'(i + 5), 4'(i + 1), 4'(i), 1, 1, 1'b1);
        @(negedge clk);
        check("fill_full_after_4", fifo_full, 1);
        check("fill_overflow_after_4", overflow, 0);
        step();
        press(4'd15, 4'd15, 4'(ADD), 1, 1, 1'b0);
        @(negedge clk);
        check("fill_overflow_after_5", overflow, 1);
        check("fill_still_full", fifo_full, 1);
        step();
        run = 1'b1;
        drain("fill");
        @(negedge clk);
        check("fill_empty_after_drain", fifo_empty, 1);
        check("fill_overflow_sticky", overflow, 1);

        // Full FIFO, push edge coincides with the first pop.
        reset_dut();
        run = 1'b0;
        for (int i = 0; i < 4; i++) press(4'(i), 4'(i + 2), 4'(OR), 1, 1, 1'b1);
        cmd_a   = 4'd12;
        cmd_b   = 4'd3;
        cmd_op  = 4'(SUBTRACT);
        cmd_btn = 1'b1;
        model_push(4'd12, 4'd3, 4'(SUBTRACT));
        step();
        step();
        run = 1'b1;                // pop and push both land on the next edge
        step();
        cmd_btn = 1'b0;
        @(negedge clk);
        check("same_cycle_overflow", overflow, 0);
        check("same_cycle_still_full", fifo_full, 1);
        step();
        drain("same_cycle");

        // Long press and single-cycle press each push exactly once.
        reset_dut();
        run = 1'b1;
        press(4'd6, 4'd6, 4'(EQUALS), 10, 4, 1'b1);
        press(4'd1, 4'd9, 4'(LT), 1, 4, 1'b1);
        drain("press_width");

        // ena low: FSM frozen mid-command and the pulse is held off.
        press(4'd7, 4'd2, 4'(GT), 1, 0, 1'b1);
        ena = 1'b0;
        repeat (5) step();
        @(negedge clk);
        check("ena_freeze_busy", busy, 1);
        check("ena_freeze_no_valid", result_valid, 0);
        check("ena_freeze_pending", sb.size(), 1);
        // An edge while disabled is lost.
        press(4'd4, 4'd4, 4'(ADD), 1, 2, 1'b0);
        ena = 1'b1;
        drain("ena");
        @(negedge clk);
        check("ena_dropped_push_empty", fifo_empty, 1);

        // Reset during EXEC of 9-2.
        reset_dut();
        run     = 1'b1;
        cmd_a   = 4'd9;
        cmd_b   = 4'd2;
        cmd_op  = 4'(SUBTRACT);
        cmd_btn = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_reached_exec", seen, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        cmd_btn   = 1'b0;
        model_acc = '0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        @(negedge clk);
        check("abort_fifo_empty", fifo_empty, 1);
        check("abort_idle", busy, 0);
        check("abort_result_zero", result, 0);

        // Chain command: 2+3, then chain ADD of 4.
        reset_dut();
        run = 1'b1;
        press(4'd2, 4'd3, 4'(ADD), 1, 4, 1'b1);
        press(4'd11, 4'd4, 4'd8, 1, 4, 1'b1);
        drain("chain");
        @(negedge clk);
`ifdef ACC_CHAIN_EN
        check("chain_final_result", result, 9);
`else
        check("chain_final_result", result, 0);
`endif

        // Randomized commands, spaced so the FIFO never overflows.
        reset_dut();
        run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            press(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), $urandom_range(1, 3),
                  $urandom_range(0, 3), 1'b1);
        end
        drain("random");
        @(negedge clk);
        check("random_overflow", overflow, 0);
        check("random_fifo_empty", fifo_empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_cmd_sequencer
